// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared constants and types for the BIP control unit and datapath
//
// Holds the instruction field widths, opcode constants, the control FSM
// state enum and the accumulator / ALU-B source select encodings.
package bip_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 11;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  // ALU B operand source select
  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - combinational opcode to control-word decoder
//
// Ports:
//   opcode     in   opcode field instr[15:11]
//   needs_mem  out  instruction reads data memory before executing
//   is_halt    out  instruction is HLT
//   sel_a      out  accumulator source select
//   sel_b      out  ALU B source select
//   op_sub     out  ALU subtract
//   wr_acc     out  accumulator write
//   wr_ram     out  data memory write
// Unlisted opcodes decode to an all-zero word (NOP).
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic                needs_mem,
  output logic                is_halt,
  output logic [1:0]          sel_a,
  output logic                sel_b,
  output logic                op_sub,
  output logic                wr_acc,
  output logic                wr_ram
);

  always_comb begin
    needs_mem = 1'b0;
    is_halt   = 1'b0;
    sel_a     = SEL_A_MEM;
    sel_b     = SEL_B_MEM;
    op_sub    = 1'b0;
    wr_acc    = 1'b0;
    wr_ram    = 1'b0;
    case (opcode)
      OP_HLT: is_halt = 1'b1;
      OP_STO: wr_ram = 1'b1;
      OP_LD: begin
        needs_mem = 1'b1;
        sel_a     = SEL_A_MEM;
        wr_acc    = 1'b1;
      end
      OP_LDI: begin
        sel_a  = SEL_A_IMM;
        wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        needs_mem = 1'b1;
        sel_a     = SEL_A_ALU;
        sel_b     = SEL_B_MEM;
        op_sub    = (opcode == OP_SUB);
        wr_acc    = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        sel_a  = SEL_A_ALU;
        sel_b  = SEL_B_IMM;
        op_sub = (opcode == OP_SUBI);
        wr_acc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// rtl/bip_control.sv - multi-cycle control unit of the BIP accumulator processor
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   i_instr        program ROM data, valid one cycle after o_pc
//   i_mem_ready    data memory read complete, sampled only in MEM
//   o_pc           program ROM address
//   o_operand      operand latched at decode (address or immediate)
//   o_sel_a        accumulator source select
//   o_sel_b        ALU B source select
//   o_op_sub       ALU subtract
//   o_wr_acc       accumulator write strobe
//   o_wr_ram       data memory write strobe
//   o_rd_ram       data memory read request, held through MEM
//   o_halted       HLT executed
//   o_cycle_count  saturating count of non-halted cycles
module bip_control
  import bip_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   i_instr,
  input  logic                 i_mem_ready,
  output logic [OPERAND_W-1:0] o_pc,
  output logic [OPERAND_W-1:0] o_operand,
  output logic [1:0]           o_sel_a,
  output logic                 o_sel_b,
  output logic                 o_op_sub,
  output logic                 o_wr_acc,
  output logic                 o_wr_ram,
  output logic                 o_rd_ram,
  output logic                 o_halted,
  output logic [CNT_W-1:0]     o_cycle_count
);

  state_t              state;
  state_t              state_nxt;
  logic [OPCODE_W-1:0] opcode_q;
  logic [OPCODE_W-1:0] dec_opcode;

  logic       dec_needs_mem;
  logic       dec_is_halt;
  logic [1:0] dec_sel_a;
  logic       dec_sel_b;
  logic       dec_op_sub;
  logic       dec_wr_acc;
  logic       dec_wr_ram;

  // In DECODE the routing decision needs the fresh ROM word; in every other
  // state the decoder sees the latched opcode. Control outputs are only taken
  // in EXEC, so they always come from the registered opcode.
  assign dec_opcode = (state == ST_DECODE) ? i_instr[INSTR_W-1:OPERAND_W] : opcode_q;

  bip_decoder u_decoder (
    .opcode    (dec_opcode),
    .needs_mem (dec_needs_mem),
    .is_halt   (dec_is_halt),
    .sel_a     (dec_sel_a),
    .sel_b     (dec_sel_b),
    .op_sub    (dec_op_sub),
    .wr_acc    (dec_wr_acc),
    .wr_ram    (dec_wr_ram)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_FETCH;
      o_pc          <= '0;
      o_operand     <= '0;
      opcode_q      <= '0;
      o_cycle_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        opcode_q  <= i_instr[INSTR_W-1:OPERAND_W];
        o_operand <= i_instr[OPERAND_W-1:0];
      end
      // Natural wrap at 2^OPERAND_W
      if (state == ST_EXEC) begin
        o_pc <= o_pc + OPERAND_W'(1);
      end
      if (state != ST_HALT && o_cycle_count != {CNT_W{1'b1}}) begin
        o_cycle_count <= o_cycle_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    o_sel_a   = SEL_A_MEM;
    o_sel_b   = SEL_B_MEM;
    o_op_sub  = 1'b0;
    o_wr_acc  = 1'b0;
    o_wr_ram  = 1'b0;
    o_rd_ram  = 1'b0;
    o_halted  = 1'b0;
    case (state)
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec_is_halt) begin
          state_nxt = ST_HALT;
        end else if (dec_needs_mem) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_MEM: begin
        o_rd_ram = 1'b1;
        if (i_mem_ready) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        o_sel_a   = dec_sel_a;
        o_sel_b   = dec_sel_b;
        o_op_sub  = dec_op_sub;
        o_wr_acc  = dec_wr_acc;
        o_wr_ram  = dec_wr_ram;
        state_nxt = ST_FETCH;
      end
      ST_HALT: o_halted = 1'b1;
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule
